// File: rtl/uart_param.sv
// uart_param: parametrised synchronous UART transceiver
// tick-enable timing, 3-sample majority RX, parity/frame flags
module uart_param #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 uart_rxd,
  output logic                 uart_txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_en,
  output logic                 tx_status,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_status,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);
  localparam int DIV16    = CLK_FREQ / (BAUD * 16);
  localparam int BIT_CYC  = 16 * DIV16;
  localparam int STOP_CYC = STOP_BITS * BIT_CYC;
  localparam int TW = (DIV16 > 1) ? $clog2(DIV16) : 1;
  localparam int CW = $clog2(STOP_CYC + 1);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP
  } tx_st_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT
  } rx_st_t;

  logic          rx_m, rx_s;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  tx_st_t               tx_st, tx_st_n;
  logic [CW-1:0]        tx_cyc, tx_cyc_n;
  logic [IW-1:0]        tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_buf, tx_buf_n;
  logic                 tx_q, tx_q_n;
  logic                 tx_par, bit_end;

  rx_st_t               rx_st, rx_st_n;
  logic [3:0]           scnt, scnt_n;
  logic [1:0]           smp, smp_n;
  logic [IW-1:0]        ridx, ridx_n;
  logic [DATA_BITS-1:0] rsh, rsh_n;
  logic                 rpar, rpar_n;
  logic [DATA_BITS-1:0] rdat_n;
  logic                 rfe_n, rpe_n, rstat_n;
  logic                 maj, exp_par;

  // two-flop synchroniser, idles high like the line
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rxd;
      rx_s <= rx_m;
    end
  end

  assign tick = (tick_cnt == TW'(DIV16 - 1));

  // free-running 16x oversample tick divider
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign tx_par  = (PARITY == 1) ? ~^tx_buf : ^tx_buf;
  assign bit_end = (tx_cyc == CW'(BIT_CYC - 1));

  // TX state register; line level is registered too
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      tx_st  <= T_IDLE;
      tx_cyc <= '0;
      tx_idx <= '0;
      tx_buf <= '0;
      tx_q   <= 1'b1;
    end else begin
      tx_st  <= tx_st_n;
      tx_cyc <= tx_cyc_n;
      tx_idx <= tx_idx_n;
      tx_buf <= tx_buf_n;
      tx_q   <= tx_q_n;
    end
  end

  // TX next state: bit length counted in sysclk cycles
  always_comb begin
    tx_st_n  = tx_st;
    tx_cyc_n = tx_cyc + 1'b1;
    tx_idx_n = tx_idx;
    tx_buf_n = tx_buf;
    unique case (tx_st)
      T_IDLE: begin
        tx_cyc_n = '0;
        if (tx_en) begin
          tx_st_n  = T_START;
          tx_buf_n = tx_data;
          tx_idx_n = '0;
        end
      end
      T_START: begin
        if (bit_end) begin
          tx_st_n  = T_DATA;
          tx_cyc_n = '0;
        end
      end
      T_DATA: begin
        if (bit_end) begin
          tx_cyc_n = '0;
          if (tx_idx == IW'(DATA_BITS - 1))
            tx_st_n = (PARITY != 0) ? T_PAR : T_STOP;
          else
            tx_idx_n = tx_idx + 1'b1;
        end
      end
      T_PAR: begin
        if (bit_end) begin
          tx_st_n  = T_STOP;
          tx_cyc_n = '0;
        end
      end
      T_STOP: begin
        if (tx_cyc == CW'(STOP_CYC - 1)) begin
          tx_st_n  = T_IDLE;
          tx_cyc_n = '0;
        end
      end
      default: tx_st_n = T_IDLE;
    endcase
  end

  // line level for the upcoming state
  always_comb begin
    tx_q_n = 1'b1;
    unique case (tx_st_n)
      T_START: tx_q_n = 1'b0;
      T_DATA:  tx_q_n = tx_buf_n[tx_idx_n];
      T_PAR:   tx_q_n = tx_par;
      default: tx_q_n = 1'b1;
    endcase
  end

  assign uart_txd  = tx_q;
  assign tx_status = (tx_st == T_IDLE);

  assign maj = (smp[1] & smp[0]) | (smp[1] & rx_s) | (smp[0] & rx_s);
  assign exp_par = (PARITY == 1) ? ~^rsh : ^rsh;

  // RX state register and result outputs
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      rx_st         <= R_IDLE;
      scnt          <= '0;
      smp           <= 2'b11;
      ridx          <= '0;
      rsh           <= '0;
      rpar          <= 1'b0;
      rx_data       <= '0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_status     <= 1'b0;
    end else begin
      rx_st         <= rx_st_n;
      scnt          <= scnt_n;
      smp           <= smp_n;
      ridx          <= ridx_n;
      rsh           <= rsh_n;
      rpar          <= rpar_n;
      rx_data       <= rdat_n;
      rx_frame_err  <= rfe_n;
      rx_parity_err <= rpe_n;
      rx_status     <= rstat_n;
    end
  end

  // RX next state: vote on samples 7/8/9, decide at 9, advance at 15
  always_comb begin
    rx_st_n = rx_st;
    scnt_n  = scnt;
    smp_n   = smp;
    ridx_n  = ridx;
    rsh_n   = rsh;
    rpar_n  = rpar;
    rdat_n  = rx_data;
    rfe_n   = rx_frame_err;
    rpe_n   = rx_parity_err;
    rstat_n = 1'b0;
    if (tick) begin
      scnt_n = scnt + 1'b1;
      if (scnt == 4'd7) smp_n[1] = rx_s;
      if (scnt == 4'd8) smp_n[0] = rx_s;
      unique case (rx_st)
        R_IDLE: begin
          scnt_n = '0;
          if (!rx_s) rx_st_n = R_START;
        end
        R_START: begin
          if (scnt == 4'd9 && maj) begin
            rx_st_n = R_IDLE;
          end else if (scnt == 4'd15) begin
            rx_st_n = R_DATA;
            ridx_n  = '0;
          end
        end
        R_DATA: begin
          if (scnt == 4'd9) rsh_n = {maj, rsh[DATA_BITS-1:1]};
          if (scnt == 4'd15) begin
            if (ridx == IW'(DATA_BITS - 1))
              rx_st_n = (PARITY != 0) ? R_PAR : R_STOP;
            else
              ridx_n = ridx + 1'b1;
          end
        end
        R_PAR: begin
          if (scnt == 4'd9)  rpar_n  = maj;
          if (scnt == 4'd15) rx_st_n = R_STOP;
        end
        R_STOP: begin
          if (scnt == 4'd9) begin
            rdat_n  = rsh;
            rfe_n   = ~maj;
            rpe_n   = (PARITY != 0) && (rpar != exp_par);
            rstat_n = 1'b1;
            rx_st_n = maj ? R_IDLE : R_WAIT;
          end
        end
        R_WAIT: begin
          scnt_n = '0;
          if (rx_s) rx_st_n = R_IDLE;
        end
        default: rx_st_n = R_IDLE;
      endcase
    end
  end
endmodule
